// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 4-digit seven-segment driver.
package seg7_pkg;

    localparam int NUM_DIGITS       = 4;
    localparam int PRESCALE_DEFAULT = 100000;

    // Active-low cathode patterns {g,f,e,d,c,b,a}, indexed by hex value.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   blank;
        logic [NUM_DIGITS-1:0]   dp;
    } disp_t;

    localparam disp_t DISP_RESET = '{digits: '0, blank: '1, dp: '0};

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit seven-segment scanner with frame-aligned double buffering.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  blank_in,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        load_ack,
    output logic        frame_done
);

    localparam int          CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] TC = CW'(PRESCALE - 1);

    logic [CW-1:0] count;
    logic          tick;
    logic          boundary;
    logic [1:0]    idx;
    disp_t         active;
    disp_t         pending;
    logic          pending_valid;

    logic [3:0]    nib;
    logic [6:0]    seg_hex;
    logic          blank_cur;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    assign tick     = (count == TC);
    assign boundary = tick && (idx == 2'd3);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            count <= '0;
            idx   <= 2'd0;
        end else if (tick) begin
            count <= '0;
            idx   <= idx + 2'd1;
        end else begin
            count <= count + 1'b1;
        end
    end

    // A load on the boundary cycle still stages; the apply uses the older pending.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            active        <= DISP_RESET;
            pending       <= '0;
            pending_valid <= 1'b0;
            load_ack      <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            load_ack   <= boundary && pending_valid;
            frame_done <= boundary;
            if (boundary && pending_valid)
                active <= pending;
            if (load) begin
                pending       <= '{digits: digits_in, blank: blank_in, dp: dp_in};
                pending_valid <= 1'b1;
            end else if (boundary) begin
                pending_valid <= 1'b0;
            end
        end
    end

    assign nib = active.digits[{idx, 2'b00} +: 4];

    seg7_hex_decode u_hex_decode (
        .hex (nib),
        .seg (seg_hex)
    );

    always_comb begin
        blank_cur = active.blank[idx];
        an_nxt    = 4'b1111;
        seg_nxt   = SEG_OFF;
        dp_nxt    = 1'b1;
        if (!blank_cur) begin
            an_nxt  = ~(4'b0001 << idx);
            seg_nxt = seg_hex;
            dp_nxt  = ~active.dp[idx];
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: time-based reference model plus directed literal checks.
module tb_seg7_scan_driver;

    localparam int P = 4;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  blank_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        load_ack;
    logic        frame_done;

    seg7_scan_driver #(.PRESCALE(P)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .load       (load),
        .digits_in  (digits_in),
        .blank_in   (blank_in),
        .dp_in      (dp_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .load_ack   (load_ack),
        .frame_done (frame_done)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int c0 = 0;
    int ack_cnt = 0;
    int fd_cnt = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slot and frame position derived from elapsed cycles since reset.
    logic [6:0]  hex7 [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    logic [3:0]  an_sel [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int          t = 0;
    logic [15:0] a_dig, p_dig;
    logic [3:0]  a_blk, p_blk, a_dp, p_dp;
    bit          pv = 0;
    bit          mvalid = 0;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_ack, e_fd;

    always @(posedge clk_in) begin : model
        int         slot;
        bit         bnd;
        logic [3:0] nib;
        if (reset) begin
            t = 0; a_dig = '0; a_blk = 4'hF; a_dp = '0; pv = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ack = 1'b0; e_fd = 1'b0;
            mvalid = 1;
        end else begin
            slot = (t / P) % 4;
            bnd  = (t % (4 * P)) == (4 * P - 1);
            nib  = a_dig[4*slot +: 4];
            if (a_blk[slot]) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an = an_sel[slot]; e_seg = hex7[nib]; e_dp = ~a_dp[slot];
            end
            e_fd  = bnd;
            e_ack = bnd && pv;
            if (bnd && pv) begin
                a_dig = p_dig; a_blk = p_blk; a_dp = p_dp; pv = 0;
            end
            if (load) begin
                p_dig = digits_in; p_blk = blank_in; p_dp = dp_in; pv = 1;
            end
            t++;
        end
    end

    always @(negedge clk_in) begin
        if (mvalid) begin
            chk("an", an, e_an);
            chk("seg", seg, e_seg);
            chk("dp", dp, e_dp);
            chk("load_ack", load_ack, e_ack);
            chk("frame_done", frame_done, e_fd);
            if (load_ack === 1'b1) ack_cnt++;
            if (frame_done === 1'b1) fd_cnt++;
        end
    end

    // Return just after edge k (counted from reset release, first edge is 0).
    task automatic at_edge(input int k);
        while (cyc - c0 < k + 1) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        reset = 1'b0;
        c0    = cyc;
    endtask

    task automatic do_load(input int k, input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
        at_edge(k - 1);
        load = 1'b1; digits_in = d; blank_in = b; dp_in = p;
        at_edge(k);
        load = 1'b0;
    endtask

    task automatic wait_fd(input int max, input string name);
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (frame_done !== 1'b1 && n < max);
        chk(name, frame_done, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [6:0] expb [4] = '{7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000};

    initial begin
        int ack0, fd0;
        bit bad_an, bad_seg, nb;
        logic [3:0] an16;
        logic [6:0] seg24;
        logic dp24;

        // reset, first load and apply
        do_reset();
        do_load(2, 16'h1234, 4'b0000, 4'b0001);
        wait_fd(40, "fd_first_timeout");
        chk("fd_first_cycle", cyc - c0, 16);
        chk("ack_with_first_fd", load_ack, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            chk("d0_an", an, 4'b1110);
            chk("d0_seg", seg, 7'b0011001);
            chk("d0_dp", dp, 1'b0);
        end
        @(negedge clk_in);
        chk("d1_an", an, 4'b1101);
        chk("d1_seg", seg, 7'b0110000);
        chk("d1_dp", dp, 1'b1);

        // two loads in one frame, latest wins
        #1;
        ack0 = ack_cnt;
        do_load(22, 16'h1111, 4'b0000, 4'b0000);
        do_load(24, 16'hABCD, 4'b0000, 4'b0000);
        wait_fd(40, "fd_latest_timeout");
        chk("fd_latest_cycle", cyc - c0, 32);
        chk("ack_latest", load_ack, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            chk("latest_seg", seg, expb[i]);
            repeat (3) @(negedge clk_in);
        end
        #1;
        chk("latest_single_ack", ack_cnt - ack0, 1);

        // load coinciding with the boundary tick
        do_reset();
        #1;
        ack0 = ack_cnt;
        do_load(5, 16'h5555, 4'b0000, 4'b0000);
        do_load(15, 16'h00F0, 4'b0000, 4'b0000);
        at_edge(15);
        @(negedge clk_in);
        chk("sim_ack1", load_ack, 1'b1);
        chk("sim_fd1", frame_done, 1'b1);
        @(negedge clk_in);
        chk("sim_5555_seg", seg, 7'b0010010);
        at_edge(31);
        @(negedge clk_in);
        chk("sim_ack2", load_ack, 1'b1);
        @(negedge clk_in);
        chk("sim_00f0_d0", seg, 7'b1000000);
        at_edge(36);
        @(negedge clk_in);
        chk("sim_00f0_d1", seg, 7'b0001110);
        at_edge(50);
        chk("sim_two_acks", ack_cnt - ack0, 2);

        // blanking of digits 1 and 3
        do_reset();
        do_load(1, 16'h8888, 4'b1010, 4'b1111);
        bad_an = 0; bad_seg = 0;
        for (int k = 16; k < 32; k++) begin
            at_edge(k);
            @(negedge clk_in);
            if (an[1] !== 1'b1 || an[3] !== 1'b1) bad_an = 1;
            if (((k / 4) % 2 == 1) && seg !== 7'h7F) bad_seg = 1;
            if (k == 16) an16 = an;
            if (k == 24) begin
                seg24 = seg;
                dp24  = dp;
            end
        end
        chk("blank_an_never_low", bad_an, 1'b0);
        chk("blank_seg_off", bad_seg, 1'b0);
        chk("blank_d0_an", an16, 4'b1110);
        chk("blank_d2_seg", seg24, 7'b0000000);
        chk("blank_d2_dp", dp24, 1'b0);

        // reset while a load is pending
        do_load(35, 16'h4321, 4'b0000, 4'b0000);
        at_edge(40);
        do_reset();
        #1;
        ack0 = ack_cnt;
        fd0  = fd_cnt;
        nb   = 0;
        for (int k = 0; k < 32; k++) begin
            at_edge(k);
            @(negedge clk_in);
            if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) nb = 1;
        end
        #1;
        chk("rst_no_ack", ack_cnt - ack0, 0);
        chk("rst_all_blank", nb, 1'b0);
        chk("rst_two_frames", fd_cnt - fd0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter PRESCALE, default 100000: clk_in cycles per digit slot (1 kHz/digit at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have input clk_in, 1 bit: system clock; all state updates on its rising edge.
REQ-003 SHALL have input reset, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have input load, 1 bit: one-cycle request to stage new display contents.
REQ-005 SHALL have input digits_in, 16 bits: four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-006 SHALL have input blank_in, 4 bits: per-digit blank, where 1 turns that digit's anode off.
REQ-007 SHALL have input dp_in, 4 bits: per-digit decimal point, where 1 lights it.
REQ-008 SHALL have output an, 4 bits: active-low anode selects, registered.
REQ-009 SHALL have output seg, 7 bits: active-low cathodes, ordered {g,f,e,d,c,b,a}, registered.
REQ-010 SHALL have output dp, 1 bit: active-low decimal point, registered.
REQ-011 SHALL have output load_ack, 1 bit: one-cycle pulse when staged contents become active.
REQ-012 SHALL have output frame_done, 1 bit: one-cycle pulse at each scan wrap from digit 3 to digit 0.

Function
REQ-013 SHALL run a prescale counter 0..PRESCALE-1 that wraps to 0; tick is asserted when count == PRESCALE-1.
REQ-014 SHALL, on each tick, advance a 2-bit scan index 0→1→2→3→0; the index SHALL hold between ticks.
REQ-015 SHALL double-buffer: a load captures digits_in, blank_in and dp_in into a pending register and sets pending_valid.
REQ-016 SHALL, on a tick with index==3, copy pending into the active register if pending_valid, clear pending_valid, and pulse load_ack the following cycle.
REQ-017 SHALL pulse frame_done the cycle after every tick with index==3, whether or not an apply occurred.
REQ-018 SHALL, when a load occurs while pending_valid=1, overwrite the pending contents (latest wins) and SHALL NOT raise an error or ack.
REQ-019 SHALL, when a load coincides with a boundary tick, apply the pre-existing pending contents (if any) and keep the new load pending for the next frame.
REQ-020 SHALL NOT let a load alter the active register or the outputs before a boundary.
REQ-021 SHALL, each cycle, register outputs from the current index and active register (one cycle latency behind index): an = one-hot-low at index, or 4'b1111 if that digit is blanked; seg = hex decode of the nibble (0-F), or 7'b1111111 if blanked; dp = ~dp bit, or 1 if blanked.
REQ-022 SHALL use the hex decode table 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

Reset
REQ-023 SHALL, on reset, set prescale=0, index=0, active digits=0, active blank=4'b1111, active dp=0, pending cleared, pending_valid=0.
REQ-024 SHALL, on reset, drive an=4'b1111, seg=7'b1111111, dp=1, load_ack=0, frame_done=0 from the next edge.
REQ-025 SHALL, on reset mid-frame, discard any pending load with no load_ack; reset SHALL take priority over load and tick.

Structure
REQ-026 SHALL place the hex-to-segment constants, NUM_DIGITS=4 and the default PRESCALE in shared package seg7_pkg.
REQ-027 SHALL implement the decode as combinational sub-module seg7_hex_decode (4-bit in, 7-bit active-low out); prescaler, scan, buffering and output registers stay in the top.

Verification (PRESCALE=4)
REQ-028 SHALL check reset: assert reset for 2 cycles, release -> an=1111, seg=1111111, dp=1, no pulses for 16 cycles until first frame_done.
REQ-029 SHALL check load/apply: load 16'h1234, blank=0000, dp=0001 at cycle 2 -> load_ack coincident with first frame_done; then an=1110, seg=0011001, dp=0 for 4 cycles; then an=1101, seg=0110000, dp=1.
REQ-030 SHALL check latest-wins: loads of 16'h1111 then 16'hABCD within one frame -> single load_ack; digits show D,C,b,A.
REQ-031 SHALL check the simultaneous case: load 16'h00F0 on the boundary tick with pending 16'h5555 -> 5555 applied now, 00F0 applied at next boundary, two load_ack pulses total.
REQ-032 SHALL check blanking: blank_in=1010 -> an[1] and an[3] never low; seg=1111111 during slots 1 and 3.
REQ-033 SHALL check reset mid-operation: reset while pending_valid=1 -> pending discarded, no load_ack, display returns to all-blank.
